// File: rtl/alu_muldiv_pkg.sv
// Shared types for the multiply/divide unit.
// util_control_t : clock/reset bundle handed to every block.
// alu_func_t     : operation codes, including the multiply/divide, HI/LO move and
//                  accumulate codes. Accumulate codes decode to no-op unless
//                  ALU_MULDIV_MADD_EN is defined.
package alu_muldiv_pkg;

   typedef struct packed {
      logic clock;
      logic reset;
   } util_control_t;

   typedef enum logic [3:0] {
      FUNC_NONE  = 4'd0,
      FUNC_MULT  = 4'd1,
      FUNC_MULTU = 4'd2,
      FUNC_DIV   = 4'd3,
      FUNC_DIVU  = 4'd4,
      FUNC_MFHI  = 4'd5,
      FUNC_MFLO  = 4'd6,
      FUNC_MTHI  = 4'd7,
      FUNC_MTLO  = 4'd8,
      FUNC_MADD  = 4'd9,
      FUNC_MADDU = 4'd10,
      FUNC_MSUB  = 4'd11,
      FUNC_MSUBU = 4'd12
   } alu_func_t;

endpackage

// File: rtl/alu_muldiv_div.sv
// Restoring radix-2 divider, one quotient bit per cycle.
// Ports: clk, reset (sync, active-high), start (one-cycle launch, captures
// operands), is_signed, dividend, divisor; done pulses in the cycle quotient and
// remainder hold the final (sign-corrected) result, DATA_W cycles after start.
module alu_muldiv_div
   import alu_muldiv_pkg::*;
#(
   parameter int unsigned DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   logic              active;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem, dq, dvs, dvd_raw;
   logic              neg_q, neg_r, div_zero;
   logic              dvd_neg, dvs_neg;
   logic [DATA_W-1:0] dvd_abs, dvs_abs;
   logic [DATA_W:0]   shifted, diff;
   logic              q_bit;
   logic [DATA_W-1:0] rem_next, dq_next;

   // Operand magnitudes for the unsigned core
   always_comb begin
      dvd_neg = is_signed & dividend[DATA_W-1];
      dvs_neg = is_signed & divisor[DATA_W-1];
      dvd_abs = dvd_neg ? -dividend : dividend;
      dvs_abs = dvs_neg ? -divisor : divisor;
   end

   // One restoring step; dq shifts dividend bits out the top and quotient bits in
   always_comb begin
      shifted  = {rem, dq[DATA_W-1]};
      diff     = shifted - {1'b0, dvs};
      q_bit    = ~diff[DATA_W];
      rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      dq_next  = {dq[DATA_W-2:0], q_bit};
   end

   // Control: iteration counter and completion pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            active <= 1'b1;
            cnt    <= '0;
         end else if (active) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

   // Datapath; the last step folds in sign fixup and the divide-by-zero result
   always_ff @(posedge clk) begin
      if (start) begin
         rem      <= '0;
         dq       <= dvd_abs;
         dvs      <= dvs_abs;
         dvd_raw  <= dividend;
         neg_q    <= dvd_neg ^ dvs_neg;
         neg_r    <= dvd_neg;
         div_zero <= (divisor == '0);
      end else if (active) begin
         rem <= rem_next;
         dq  <= dq_next;
         if (cnt == CNT_W'(DATA_W - 1)) begin
            if (div_zero) begin
               quotient  <= '1;
               remainder <= dvd_raw;
            end else begin
               quotient  <= neg_q ? -dq_next : dq_next;
               remainder <= neg_r ? -rem_next : rem_next;
            end
         end
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Multiply/divide unit with HI/LO result registers.
// Ports: ctrl (clock, sync active-high reset), valid/func/data1/data2 request,
// result (Mfhi/Mflo read data, combinational on acceptance), busy, done.
// Optional feature: ALU_MULDIV_MADD_EN enables Madd/Maddu/Msub/Msubu.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MUL_DELAY = 2
)(
   input  util_control_t     ctrl,
   input  logic              valid,
   input  alu_func_t         func,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   output logic [DATA_W-1:0] result,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = (MUL_DELAY > 1) ? $clog2(MUL_DELAY) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

   state_t            state;
   logic [DATA_W-1:0] hi, lo;
   logic [CNT_W-1:0]  cnt;
   logic [PROD_W-1:0] pipe [MUL_DELAY];
   logic [PROD_W-1:0] mul_a, mul_b, product, mul_final;
   logic              accept, mul_start, mul_signed, div_start;
   logic              div_done;
   logic [DATA_W-1:0] div_q, div_r;
`ifdef ALU_MULDIV_MADD_EN
   logic              acc_en, acc_sub;
   logic              acc_en_d, acc_sub_d;
`endif

   // Request decode; busy is low only in IDLE, so acceptance implies IDLE
   always_comb begin
      accept     = valid & ~busy & ~ctrl.reset;
      mul_start  = 1'b0;
      mul_signed = 1'b0;
      div_start  = 1'b0;
`ifdef ALU_MULDIV_MADD_EN
      acc_en_d   = 1'b0;
      acc_sub_d  = 1'b0;
`endif
      case (func)
         FUNC_MULT: begin
            mul_start  = accept;
            mul_signed = 1'b1;
         end
         FUNC_MULTU: mul_start = accept;
`ifdef ALU_MULDIV_MADD_EN
         FUNC_MADD, FUNC_MSUB: begin
            mul_start  = accept;
            mul_signed = 1'b1;
            acc_en_d   = 1'b1;
            acc_sub_d  = (func == FUNC_MSUB);
         end
         FUNC_MADDU, FUNC_MSUBU: begin
            mul_start  = accept;
            acc_en_d   = 1'b1;
            acc_sub_d  = (func == FUNC_MSUBU);
         end
`endif
         FUNC_DIV, FUNC_DIVU: div_start = accept;
         default: ;
      endcase
   end

   // HI/LO read port
   always_comb begin
      result = '0;
      if (accept && func == FUNC_MFHI) result = hi;
      else if (accept && func == FUNC_MFLO) result = lo;
   end

   // Full-width product; sign/zero extension makes the 2W-bit truncation exact
   always_comb begin
      mul_a   = mul_signed ? {{DATA_W{data1[DATA_W-1]}}, data1} : {{DATA_W{1'b0}}, data1};
      mul_b   = mul_signed ? {{DATA_W{data2[DATA_W-1]}}, data2} : {{DATA_W{1'b0}}, data2};
      product = mul_a * mul_b;
   end

   // Product pipeline; only the entry launched at acceptance reaches the tail in time
   always_ff @(posedge ctrl.clock) begin
      if (mul_start) pipe[0] <= product;
      for (int unsigned i = 1; i < MUL_DELAY; i++) pipe[i] <= pipe[i-1];
   end

   // Value written to {HI,LO} at the end of a multiply
   always_comb begin
      mul_final = pipe[MUL_DELAY-1];
`ifdef ALU_MULDIV_MADD_EN
      if (acc_en) begin
         if (acc_sub) mul_final = {hi, lo} - pipe[MUL_DELAY-1];
         else         mul_final = {hi, lo} + pipe[MUL_DELAY-1];
      end
`endif
   end

   alu_muldiv_div #(.DATA_W(DATA_W)) u_div (
      .clk       (ctrl.clock),
      .reset     (ctrl.reset),
      .start     (div_start),
      .is_signed (func == FUNC_DIV),
      .dividend  (data1),
      .divisor   (data2),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   // Control FSM and HI/LO registers
   always_ff @(posedge ctrl.clock) begin
      if (ctrl.reset) begin
         state   <= ST_IDLE;
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef ALU_MULDIV_MADD_EN
         acc_en  <= 1'b0;
         acc_sub <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (mul_start) begin
                  state   <= ST_MUL;
                  busy    <= 1'b1;
`ifdef ALU_MULDIV_MADD_EN
                  acc_en  <= acc_en_d;
                  acc_sub <= acc_sub_d;
`endif
               end else if (div_start) begin
                  state <= ST_DIV;
                  busy  <= 1'b1;
               end else if (accept && func == FUNC_MTHI) begin
                  hi <= data1;
               end else if (accept && func == FUNC_MTLO) begin
                  lo <= data1;
               end
            end
            ST_MUL: begin
               if (cnt == CNT_W'(MUL_DELAY - 1)) begin
                  {hi, lo} <= mul_final;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DIV: begin
               if (div_done) begin
                  hi    <= div_r;
                  lo    <= div_q;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (DATA_W=4, MUL_DELAY=2): directed cases
// with literal expectations, then randomized traffic against a behavioural model
// of HI/LO and operation latency. Honors ALU_MULDIV_MADD_EN when defined.
module tb_alu_muldiv;
   import alu_muldiv_pkg::*;

   localparam int unsigned DW = 4;
   localparam int unsigned MD = 2;

   logic          clk;
   logic          rst;
   util_control_t ctrl;
   logic          valid;
   alu_func_t     func;
   logic [DW-1:0] data1, data2;
   logic [DW-1:0] result;
   logic          busy, done;

   assign ctrl = '{clock: clk, reset: rst};

   alu_muldiv #(.DATA_W(DW), .MUL_DELAY(MD)) dut (
      .ctrl   (ctrl),
      .valid  (valid),
      .func   (func),
      .data1  (data1),
      .data2  (data2),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Behavioural model: architectural HI/LO, pending result, cycles of busy left
   logic [DW-1:0] m_hi, m_lo, p_hi, p_lo;
   int            m_rem = 0;
   bit            m_done = 0;
   bit            model_ok = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [2*DW-1:0] mul_ref(input bit sgn, input logic [DW-1:0] a, input logic [DW-1:0] b);
      int x, y;
      x = sgn ? int'($signed(a)) : int'(a);
      y = sgn ? int'($signed(b)) : int'(b);
      return (2*DW)'(x * y);
   endfunction

   task automatic div_ref(input bit sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] q, output logic [DW-1:0] r);
      int x, y;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (sgn) begin
         x = int'($signed(a));
         y = int'($signed(b));
         q = DW'(x / y);   // integer division truncates toward zero
         r = DW'(x % y);   // remainder follows the dividend's sign
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   function automatic logic [DW-1:0] exp_result();
      bit acc;
      acc = valid && (m_rem == 0) && !rst;
      if (acc && func == FUNC_MFHI) return m_hi;
      if (acc && func == FUNC_MFLO) return m_lo;
      return '0;
   endfunction

   // Advance the model across one rising edge using the inputs presented to it
   task automatic model_step();
      logic [2*DW-1:0] prod;
      if (rst) begin
         m_hi = '0; m_lo = '0; m_rem = 0; m_done = 0; model_ok = 1;
      end else begin
         m_done = 0;
         if (m_rem != 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1;
            end
         end else if (valid) begin
            case (func)
               FUNC_MULT, FUNC_MULTU: begin
                  {p_hi, p_lo} = mul_ref(func == FUNC_MULT, data1, data2);
                  m_rem = MD;
               end
`ifdef ALU_MULDIV_MADD_EN
               FUNC_MADD, FUNC_MADDU: begin
                  prod = mul_ref(func == FUNC_MADD, data1, data2);
                  {p_hi, p_lo} = {m_hi, m_lo} + prod;
                  m_rem = MD;
               end
               FUNC_MSUB, FUNC_MSUBU: begin
                  prod = mul_ref(func == FUNC_MSUB, data1, data2);
                  {p_hi, p_lo} = {m_hi, m_lo} - prod;
                  m_rem = MD;
               end
`endif
               FUNC_DIV, FUNC_DIVU: begin
                  div_ref(func == FUNC_DIV, data1, data2, p_lo, p_hi);
                  m_rem = DW + 1;
               end
               FUNC_MTHI: m_hi = data1;
               FUNC_MTLO: m_lo = data1;
               default: prod = '0;
            endcase
         end
      end
   endtask

   task automatic cmp_cycle();
      if (model_ok) begin
         chk("busy",   32'(busy),   32'(m_rem != 0));
         chk("done",   32'(done),   32'(m_done));
         chk("result", 32'(result), 32'(exp_result()));
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) cmp_cycle();

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic v, input alu_func_t f, input logic [DW-1:0] a, input logic [DW-1:0] b);
      valid = v; func = f; data1 = a; data2 = b;
   endtask

   task automatic issue(input alu_func_t f, input logic [DW-1:0] a, input logic [DW-1:0] b);
      set_in(1'b1, f, a, b);
      tick();
      set_in(1'b0, FUNC_NONE, '0, '0);
   endtask

   // Count busy cycles after an accepted op, then expect the done pulse
   task automatic run_busy(input string name, input int exp_cycles);
      int n;
      bit ended;
      n = 0;
      ended = 0;
      for (int k = 0; k < 40 && !ended; k++) begin
         @(negedge clk); #1;
         if (busy) n++;
         else begin
            ended = 1;
            chk($sformatf("%s done", name), 32'(done), 32'd1);
         end
         tick();
      end
      chk($sformatf("%s busy cycles", name), 32'(n), 32'(exp_cycles));
   endtask

   task automatic read(input string name, input alu_func_t f, input logic [DW-1:0] exp);
      set_in(1'b1, f, '0, '0);
      @(negedge clk); #1;
      chk(name, 32'(result), 32'(exp));
      tick();
      set_in(1'b0, FUNC_NONE, '0, '0);
   endtask

   initial begin
      int  waited;
      bit  got;
      rst = 1'b1;
      set_in(1'b0, FUNC_NONE, '0, '0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      @(negedge clk); #1;
      chk("reset busy", 32'(busy), 32'd0);
      tick();
      read("reset hi", FUNC_MFHI, 4'h0);
      read("reset lo", FUNC_MFLO, 4'h0);

      // Multiplies
      issue(FUNC_MULTU, 4'ha, 4'ha);
      run_busy("multu", 2);
      read("multu hi", FUNC_MFHI, 4'h6);
      read("multu lo", FUNC_MFLO, 4'h4);
      issue(FUNC_MULT, 4'hd, 4'h3);
      run_busy("mult", 2);
      read("mult hi", FUNC_MFHI, 4'hf);
      read("mult lo", FUNC_MFLO, 4'h7);

      // Divides
      issue(FUNC_DIV, 4'h9, 4'h2);
      run_busy("div", 5);
      read("div lo", FUNC_MFLO, 4'hd);
      read("div hi", FUNC_MFHI, 4'hf);
      issue(FUNC_DIVU, 4'h7, 4'h0);
      run_busy("divu by zero", 5);
      read("div0 lo", FUNC_MFLO, 4'hf);
      read("div0 hi", FUNC_MFHI, 4'h7);
      issue(FUNC_DIV, 4'h8, 4'hf);
      run_busy("div min", 5);
      read("min lo", FUNC_MFLO, 4'h8);
      read("min hi", FUNC_MFHI, 4'h0);

      // Register moves
      issue(FUNC_MTHI, 4'h5, 4'h0);
      read("mthi", FUNC_MFHI, 4'h5);
      issue(FUNC_MTLO, 4'h9, 4'h0);
      read("mtlo", FUNC_MFLO, 4'h9);

      // Mflo held through a divide stalls until busy falls
      issue(FUNC_DIVU, 4'h7, 4'h3);
      set_in(1'b1, FUNC_MFLO, 4'hf, 4'hf);
      waited = 0;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk); #1;
         if (busy) begin
            chk("mflo stalled", 32'(result), 32'd0);
            waited++;
         end else begin
            chk("mflo after divu", 32'(result), 32'h2);
            got = 1;
         end
         tick();
      end
      chk("mflo wait cycles", 32'(waited), 32'd5);
      set_in(1'b0, FUNC_NONE, '0, '0);
      read("divu hi", FUNC_MFHI, 4'h1);

      // Reset aborts an in-flight divide
      issue(FUNC_DIVU, 4'h7, 4'h3);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk); #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      repeat (7) tick();
      read("abort hi", FUNC_MFHI, 4'h0);
      read("abort lo", FUNC_MFLO, 4'h0);

`ifdef ALU_MULDIV_MADD_EN
      issue(FUNC_MTHI, 4'h0, 4'h0);
      issue(FUNC_MTLO, 4'hf, 4'h0);
      issue(FUNC_MADDU, 4'h1, 4'h1);
      run_busy("maddu", 2);
      read("maddu hi", FUNC_MFHI, 4'h1);
      read("maddu lo", FUNC_MFLO, 4'h0);
`endif

      // Randomized traffic; inputs keep changing while busy
      for (int i = 0; i < 1500; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         valid = ($urandom_range(0, 3) != 0);
         func  = alu_func_t'(4'($urandom_range(0, 12)));
         data1 = DW'($urandom);
         data2 = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            data1 = 4'h8;
            data2 = 4'hf;
         end
         tick();
      end
      rst = 1'b0;
      set_in(1'b0, FUNC_NONE, '0, '0);
      repeat (8) tick();

      @(negedge clk); #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: Alu_muldiv

Interface
REQ-001 The parameter DATA_W SHALL default to 32 and set the operand, result, HI and LO width (min 4).
REQ-002 The parameter MUL_DELAY SHALL default to 2 and set the multiply latency in cycles (min 1).
REQ-003 The port ctrl SHALL be an input of type `Util_Control_T`; its clock field is the single rising-edge clock.
REQ-004 The reset field of ctrl SHALL be the reset, which is synchronous and active-high.
REQ-005 valid  input  1  marks func/data1/data2 as a request this cycle.
REQ-006 func  input  `Alu_Func_T`  selects the operation: None, Mult, Multu, Div, Divu, Mfhi, Mflo, Mthi, Mtlo.
REQ-007 data1, data2  input  DATA_W  data1 is the multiplicand or dividend; data2 is the multiplier or divisor.
REQ-008 result  output  DATA_W  carries the Mfhi/Mflo read data.
REQ-009 busy  output  1  is high while a multiply or divide is in flight.
REQ-010 done  output  1  is a one-cycle pulse in the cycle HI/LO are updated by a multiply or divide.

Function
REQ-011 A request SHALL be accepted only when valid=1 and busy=0; an unaccepted request is held by the producer and ignored by the block.
REQ-012 The FSM SHALL have three states: IDLE, MUL and DIV. IDLE goes to MUL on an accepted Mult/Multu and to DIV on an accepted Div/Divu; MUL and DIV return to IDLE in their done cycle.
REQ-013 Mult/Multu SHALL set busy the cycle after acceptance for MUL_DELAY cycles; done then pulses and {HI,LO} becomes the 2*DATA_W product, signed or unsigned.
REQ-014 Div/Divu SHALL use a restoring radix-2 iteration: busy for DATA_W+1 cycles (sign fixup included), then done; LO is the quotient and HI the remainder.
REQ-015 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-016 Divide by zero SHALL give LO=all-ones and HI=dividend, with the same latency as a normal divide.
REQ-017 Signed MIN / -1 SHALL give LO=MIN and HI=0.
REQ-018 Mthi/Mtlo SHALL write data1 into HI/LO at the accepting edge, single cycle, with no busy.
REQ-019 Mfhi/Mflo SHALL drive HI/LO combinationally on result when accepted; otherwise result is 0.
REQ-020 Mfhi/Mflo/Mthi/Mtlo presented while busy=1 SHALL stall under the REQ-011 rule and SHALL NOT observe or modify in-flight state.
REQ-021 Operands SHALL be captured at acceptance; input changes during busy SHALL have no effect.

Reset
REQ-022 When reset=1 at a rising edge, HI, LO and the iteration counter SHALL clear to 0, the FSM SHALL go to IDLE, and busy and done SHALL clear to 0, including when an operation is in flight (it is aborted with no done).
REQ-023 During reset, result SHALL read 0 and requests SHALL be ignored.

Configuration
REQ-024 With ALU_MULDIV_MADD_EN defined, func SHALL also accept Madd, Maddu, Msub and Msubu: {HI,LO} +/- the product after MUL_DELAY cycles, wrapping modulo 2^(2*DATA_W).
REQ-025 Without ALU_MULDIV_MADD_EN, those codes SHALL be treated as None and no accumulate adder SHALL be synthesised.

Structure
REQ-026 New func codes (Mult, Multu, Div, Divu, Mtlo, Madd, Maddu, Msub, Msubu) SHALL be added to the shared Alu/Func.v `Alu_Func_T` definitions; the FSM state encoding SHALL stay local to the block.
REQ-027 The divider datapath SHALL be a sub-module Alu_muldiv_div (start/done, DATA_W parameter); the multiply SHALL be a MUL_DELAY-deep register pipeline inside Alu_muldiv.

Verification (DATA_W=4, MUL_DELAY=2)
REQ-028 Multu 0xa*0xa -> busy for 2 cycles, done pulse, HI=0x6, LO=0x4; Mfhi then gives result=0x6.
REQ-029 Mult 0xd(-3)*0x3 -> HI=0xf, LO=0x7; Div 0x9(-7)/0x2 -> LO=0xd, HI=0xf, busy for 5 cycles.
REQ-030 Divu 0x7/0x0 -> LO=0xf, HI=0x7; Div 0x8/0xf -> LO=0x8, HI=0x0.
REQ-031 Mflo with valid held during Divu 0x7/0x3 -> not accepted until busy falls, then result=0x2, and HI reads 0x1.
REQ-032 Reset asserted 2 cycles into a Divu -> busy=0 the next cycle, no done pulse, Mfhi/Mflo return 0.
REQ-033 With ALU_MULDIV_MADD_EN: Mthi 0x0, Mtlo 0xf, then Maddu 0x1*0x1 -> HI=0x1, LO=0x0.
